// File: rtl/freq_disp_pkg.sv
// Shared types and segment patterns for the frequency display controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package freq_disp_pkg;

  typedef enum logic [1:0] {
    S_NODATA,
    S_VALUE,
    S_OFLO,
    S_UFLO
  } disp_mode_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_E     = 7'h06;

endpackage

// File: rtl/sseg_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Codes above 9 are not valid BCD and show 'E'.
module sseg_decoder
  import freq_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/freq_display_ctrl.sv
// Captures a BCD frequency result and scans it onto a 4-digit common-anode display.
// state    | meaning
// S_NODATA | no result since reset, show "----"
// S_VALUE  | valid result, show digits with leading-zero blanking and DP
// S_OFLO   | last result above range, show "  OF"
// S_UFLO   | last result below range, show "  UF"
module freq_display_ctrl
  import freq_disp_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_done,
  input  logic [3:0] i_bcd3,
  input  logic [3:0] i_bcd2,
  input  logic [3:0] i_bcd1,
  input  logic [3:0] i_bcd0,
  input  logic [3:0] i_dp,
  input  logic       i_overflow,
  input  logic       i_underflow,
  output logic [3:0] o_an,
  output logic [7:0] o_sseg,
  output logic       o_stale
);

  disp_mode_t mode_q, mode_d;
  logic [3:0][3:0] digits_q;
  logic [3:0]      dp_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]      sel;
  logic [3:0]      blank_mask;
  logic            zero_above;
  logic [6:0]      dec_seg;
  logic [7:0]      seg_next;
  logic [3:0]      an_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mode_q <= S_NODATA;
    else          mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (i_done) begin
      if (i_overflow)       mode_d = S_OFLO;
      else if (i_underflow) mode_d = S_UFLO;
      else                  mode_d = S_VALUE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      digits_q <= '0;
      dp_q     <= '0;
    end else if (i_done) begin
      digits_q <= {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
      dp_q     <= i_dp;
    end
  end

  // A start in the same cycle as a done still marks the new value as stale.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     o_stale <= 1'b0;
    else if (i_start) o_stale <= 1'b1;
    else if (i_done)  o_stale <= 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) refresh_q <= '0;
    else          refresh_q <= refresh_q + 1'b1;
  end

  assign sel = refresh_q[REFRESH_BITS-1 -: 2];

  // Blank a digit only if it and everything above it is zero and it sits left of the DP.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      zero_above    = zero_above & (digits_q[k] == 4'd0);
      blank_mask[k] = zero_above & ((dp_q[3:2] != 2'b00) | (2'(k) > dp_q[1:0]));
    end
  end

  sseg_decoder u_dec (
    .bcd (digits_q[sel]),
    .seg (dec_seg)
  );

  always_comb begin
    seg_next = {1'b1, SEG_BLANK};
    case (mode_q)
      S_NODATA: seg_next = {1'b1, SEG_DASH};
      S_OFLO: begin
        if (sel == 2'd0)      seg_next = {1'b1, SEG_F};
        else if (sel == 2'd1) seg_next = {1'b1, SEG_O};
      end
      S_UFLO: begin
        if (sel == 2'd0)      seg_next = {1'b1, SEG_F};
        else if (sel == 2'd1) seg_next = {1'b1, SEG_U};
      end
      S_VALUE: begin
        seg_next[6:0] = blank_mask[sel] ? SEG_BLANK : dec_seg;
        seg_next[7]   = (dp_q != {2'b00, sel});
      end
      default: seg_next = {1'b1, SEG_BLANK};
    endcase
  end

  assign an_next = ~(4'b0001 << sel);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_an   <= 4'b1111;
      o_sseg <= 8'hFF;
    end else begin
      o_an   <= an_next;
      o_sseg <= seg_next;
    end
  end

endmodule

// File: tb/tb_freq_display_ctrl.sv
// Scoreboard bench for freq_display_ctrl with a 16-clock scan frame.
// Stimulus queues expected frames; the monitor checks each digit as the scan reaches it.
module tb_freq_display_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_done = 1'b0;
  logic [3:0] i_bcd3 = '0, i_bcd2 = '0, i_bcd1 = '0, i_bcd0 = '0;
  logic [3:0] i_dp = '0;
  logic       i_overflow = 1'b0;
  logic       i_underflow = 1'b0;
  logic [3:0] o_an;
  logic [7:0] o_sseg;
  logic       o_stale;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0][7:0] seg;
    logic            stale;
    string           name;
  } frame_t;

  frame_t exp_q[$];

  always #5 i_clk = ~i_clk;

  freq_display_ctrl #(.REFRESH_BITS(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_done      (i_done),
    .i_bcd3      (i_bcd3),
    .i_bcd2      (i_bcd2),
    .i_bcd1      (i_bcd1),
    .i_bcd0      (i_bcd0),
    .i_dp        (i_dp),
    .i_overflow  (i_overflow),
    .i_underflow (i_underflow),
    .o_an        (o_an),
    .o_sseg      (o_sseg),
    .o_stale     (o_stale)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // segs packed {digit3, digit2, digit1, digit0}
  task automatic push(input string nm, input logic [31:0] segs, input logic st);
    frame_t f;
    f.seg   = segs;
    f.stale = st;
    f.name  = nm;
    exp_q.push_back(f);
  endtask

  task automatic drain();
    for (int i = 0; i < 120 && exp_q.size() != 0; i++) @(negedge i_clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d frames still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic result(input logic [3:0] b3, b2, b1, b0, dp,
                        input logic ovf, unf, st);
    @(negedge i_clk);
    {i_bcd3, i_bcd2, i_bcd1, i_bcd0} = {b3, b2, b1, b0};
    i_dp = dp; i_overflow = ovf; i_underflow = unf;
    i_done = 1'b1; i_start = st;
    @(negedge i_clk);
    i_done = 1'b0; i_start = 1'b0;
    {i_bcd3, i_bcd2, i_bcd1, i_bcd0} = '0;
    i_dp = '0; i_overflow = 1'b0; i_underflow = 1'b0;
    @(negedge i_clk);
  endtask

  // Monitor: a frame is checked from the first digit-0 appearance after it is queued.
  initial begin
    int         idx = -1;
    logic [3:0] last_an = 4'hF;
    frame_t     cur;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() == 0) idx = -1;
      if (o_an != last_an) begin
        if (idx < 0 && exp_q.size() > 0 && o_an == 4'b1110) idx = 0;
        if (idx >= 0) begin
          cur = exp_q[0];
          check({cur.name, "_an"},    32'(o_an),    32'(~(4'b0001 << idx) & 4'hF));
          check({cur.name, "_seg"},   32'(o_sseg),  32'(cur.seg[idx]));
          check({cur.name, "_stale"}, 32'(o_stale), 32'(cur.stale));
          idx++;
          if (idx == 4) begin
            void'(exp_q.pop_front());
            idx = -1;
          end
        end
      end
      last_an = o_an;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected done", $time);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_an",    32'(o_an),    32'h0000000F);
    check("rst_sseg",  32'(o_sseg),  32'h000000FF);
    check("rst_stale", 32'(o_stale), 32'h00000000);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    push("nodata0", 32'hBFBFBFBF, 1'b0);
    push("nodata1", 32'hBFBFBFBF, 1'b0);
    drain();

    result(4'd1, 4'd4, 4'd9, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    push("val1493", 32'hF9991_0B0 >> 0, 1'b0);
    drain();

    result(4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0);
    push("lzb0012", 32'hFFFFF9A4, 1'b0);
    drain();

    result(4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    push("lzb0005dp0", 32'hFFFFFF12, 1'b0);
    drain();

    result(4'd0, 4'hA, 4'd0, 4'd7, 4'd4, 1'b0, 1'b0, 1'b0);
    push("illegal_e", 32'hFF86C0F8, 1'b0);
    drain();

    result(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0);
    push("allzero_nodp", 32'hFFFFFFC0, 1'b0);
    drain();

    result(4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    push("allzero_dp3", 32'h40C0C0C0, 1'b0);
    drain();

    result(4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 1'b1, 1'b1, 1'b0);
    push("oflo", 32'hFFFFC08E, 1'b0);
    drain();

    result(4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1, 1'b0);
    push("uflo", 32'hFFFFC18E, 1'b0);
    drain();

    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    push("stale_hold", 32'hFFFFC18E, 1'b1);
    repeat (36) @(negedge i_clk);
    check("stale_before_done", 32'(o_stale), 32'h1);
    check("stale_frame_seen", 32'(exp_q.size()), 32'h0);

    result(4'd0, 4'd2, 4'd5, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    push("val0250dp2", 32'hFF2492C0, 1'b0);
    drain();

    result(4'd9, 4'd8, 4'd7, 4'd6, 4'd4, 1'b0, 1'b0, 1'b1);
    push("start_and_done", 32'h9080F882, 1'b1);
    drain();

    @(negedge i_clk);
    {i_bcd3, i_bcd2, i_bcd1, i_bcd0} = 16'h1234;
    i_dp = 4'd0; i_overflow = 1'b1;
    push("inputs_ignored", 32'h9080F882, 1'b1);
    drain();
    {i_bcd3, i_bcd2, i_bcd1, i_bcd0} = '0;
    i_dp = '0; i_overflow = 1'b0;

    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_an",    32'(o_an),    32'h0000000F);
    check("midrst_sseg",  32'(o_sseg),  32'h000000FF);
    check("midrst_stale", 32'(o_stale), 32'h00000000);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    push("after_rst", 32'hBFBFBFBF, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
